iic_cond_gen: RTL and testbench
===============================

Name: iic_cond_gen

Overview:
Parametrised I2C bus-condition generator. Produces START, repeated START and STOP on open-drain SCL/SDA from a single command handshake. Owns its own quarter-period SCL timing and supports SCL clock stretching, a stretch timeout and STOP arbitration checking. Sits between the IIC byte engine (command source) and the pad open-drain drivers.

Parameters:
CLK_DIV, 250, clk cycles per SCL quarter period (100 MHz / (4*250) = 100 kHz); legal range 2..65535.
STRETCH_MAX, 100000, max clk cycles to wait for scl_in high; 0 disables the timeout.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_op  in  2  00 START, 01 RESTART, 10 STOP, 11 reserved
cmd_ready  out  1  block idle; command accepted when cmd_valid && cmd_ready
done  out  1  one-cycle pulse, condition completed successfully
err  out  1  one-cycle pulse: illegal op, wrong bus state, or stretch timeout
arb_lost  out  1  one-cycle pulse: SDA not high at end of STOP
bus_busy  out  1  high from START completion until STOP completion or error
scl_in  in  1  SCL pad level (asynchronous)
sda_in  in  1  SDA pad level (asynchronous)
scl_oe  out  1  1 = drive SCL low, 0 = release
sda_oe  out  1  1 = drive SDA low, 0 = release

Behaviour:
- Reset: scl_oe=0, sda_oe=0, cmd_ready=1, done=0, err=0, arb_lost=0, bus_busy=0, FSM IDLE, timer cleared. Reset mid-condition releases both lines immediately (asynchronous).
- All outputs are registered. scl_in/sda_in pass through a 2-FF synchroniser; all decisions use the synchronised values.
- Accept on cycle T. cmd_ready drops at T+1. Each phase lasts exactly CLK_DIV cycles unless it is a wait phase.
- START (requires bus_busy=0): P0 release both; P1 sda_oe=1; P2 scl_oe=1.
- RESTART (requires bus_busy=1): P0 sda_oe=0 (SCL still low); P1 scl_oe=0 and wait for scl_in high, then CLK_DIV cycles; P2 sda_oe=1; P3 scl_oe=1.
- STOP (requires bus_busy=1): P0 sda_oe=1; P1 scl_oe=0 and wait for scl_in high, then CLK_DIV cycles; P2 sda_oe=0; P3 sample sda_in at the end of the phase.
- After the last phase, done pulses for one cycle and cmd_ready returns high in the same cycle.
  - START with no stretch: done at T+1+3*CLK_DIV.
  - RESTART/STOP with no stretch: done at T+1+4*CLK_DIV+2 (2 = synchroniser delay).
- bus_busy is set with START done and cleared with STOP done.
- STOP end, sda_in low: arb_lost pulses instead of done; bus_busy clears; both lines released.
- Illegal commands: op=11, START while busy, or RESTART/STOP while idle. err pulses at T+1 and cmd_ready is high again at T+2. No line changes.
- Stretch wait: the timer is held while scl_in is low. If STRETCH_MAX>0 and the wait reaches STRETCH_MAX cycles:
  - err pulses;
  - scl_oe=0, sda_oe=0, bus_busy=0;
  - FSM returns to IDLE.
- cmd_valid while cmd_ready=0 is ignored; no queueing.
- Quarter counter runs from CLK_DIV-1 down to 0 and wraps on phase advance. The stretch counter saturates. Widths are $clog2 of the respective maxima.
- FSM states: IDLE, CHECK, PHASE (with 2-bit phase index), WAIT_SCL, FINISH. CHECK validates op against bus_busy. FINISH emits done/arb_lost.

Decomposition:
- Package iic_pkg holds:
  - op code constants IIC_OP_START/RESTART/STOP/RSVD;
  - the FSM state enum typedef;
  - the phase-index typedef.
- One sub-module: iic_qtr_timer. It is a loadable down-counter with hold input and terminal-count strobe, parametrised by CLK_DIV.
- The synchroniser stays inline in iic_cond_gen.

Test Plan:
- CLK_DIV=4, START at T → sda_oe rises T+5, scl_oe rises T+9, done pulse at T+13, bus_busy=1 at T+14.
- After START, STOP, scl_in follows ~scl_oe, sda_in follows ~sda_oe → sda_oe=1, SCL released, SDA released, done at T+19, bus_busy=0.
- After START, RESTART with scl_in forced low for 50 cycles after release → P1 extended by exactly 50 cycles; done 50 cycles later than the unstretched case.
- STRETCH_MAX=20, STOP with scl_in held low → err pulse 20 cycles into the wait; scl_oe=0, sda_oe=0, bus_busy=0.
- STOP with sda_in forced low during P3 → arb_lost pulse, no done, bus_busy=0.
- Error and reset cases:
  - STOP while idle → err at T+1, no oe change.
  - op=11 → err at T+1, no oe change.
  - rst_n pulsed mid-RESTART → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared op codes, FSM state and phase types for the I2C condition generator
package iic_pkg;

  localparam logic [1:0] IIC_OP_START   = 2'b00;
  localparam logic [1:0] IIC_OP_RESTART = 2'b01;
  localparam logic [1:0] IIC_OP_STOP    = 2'b10;
  localparam logic [1:0] IIC_OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PHASE,
    ST_WAIT_SCL,
    ST_FINISH
  } state_t;

  typedef logic [1:0] phase_t;

  // START needs an idle bus, RESTART/STOP need an owned bus, the reserved code is never legal.
  function automatic logic op_legal(input logic [1:0] op, input logic busy);
    logic ok;
    case (op)
      IIC_OP_START:                ok = !busy;
      IIC_OP_RESTART, IIC_OP_STOP: ok = busy;
      IIC_OP_RSVD:                 ok = 1'b0;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/iic_qtr_timer.sv
// rtl/iic_qtr_timer.sv - quarter-period down-counter with reload, hold and terminal-count strobe
module iic_qtr_timer #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic hold,
  output logic tc
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= TOP;
    end else if (!hold && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0) && !hold;

endmodule

// File: rtl/iic_cond_gen.sv
// rtl/iic_cond_gen.sv - I2C START / repeated START / STOP generator with clock stretching,
// stretch timeout and STOP arbitration check
module iic_cond_gen
  import iic_pkg::*;
#(
  parameter int CLK_DIV     = 250,
  parameter int STRETCH_MAX = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       done,
  output logic       err,
  output logic       arb_lost,
  output logic       bus_busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int SW = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX + 1) : 1;
  localparam logic [SW-1:0] STRETCH_LAST = SW'((STRETCH_MAX > 0) ? STRETCH_MAX - 1 : 0);

  state_t        state;
  phase_t        phase;
  logic [1:0]    op_q;
  logic [SW-1:0] stretch_cnt;
  logic          scl_meta, scl_s, sda_meta, sda_s;
  logic          accept, tmr_load, tmr_hold, tc;

  // Idle bus reads high, so the synchronisers reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_s    <= scl_meta;
      sda_meta <= sda_in;
      sda_s    <= sda_meta;
    end
  end

  assign accept   = cmd_valid && cmd_ready;
  assign tmr_load = accept || (state == ST_PHASE && tc);
  assign tmr_hold = (state == ST_WAIT_SCL) && !scl_s;

  iic_qtr_timer #(.CLK_DIV(CLK_DIV)) u_qtr_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .hold  (tmr_hold),
    .tc    (tc)
  );

  // The CHECK cycle doubles as the first cycle of P0, so the timer is loaded on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      op_q        <= IIC_OP_START;
      stretch_cnt <= '0;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      arb_lost    <= 1'b0;
      bus_busy    <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      arb_lost <= 1'b0;
      case (state)
        ST_IDLE, ST_FINISH: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          if (accept) begin
            state     <= ST_CHECK;
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            if (!op_legal(cmd_op, bus_busy)) begin
              err <= 1'b1;
            end else if (cmd_op == IIC_OP_RESTART) begin
              sda_oe <= 1'b0;
            end else if (cmd_op == IIC_OP_STOP) begin
              sda_oe <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          if (!op_legal(op_q, bus_busy)) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            state <= ST_PHASE;
            phase <= 2'd0;
          end
        end

        ST_PHASE: begin
          if (tc) begin
            case (phase)
              2'd0: begin
                phase <= 2'd1;
                if (op_q == IIC_OP_START) begin
                  sda_oe <= 1'b1;
                end else begin
                  scl_oe      <= 1'b0;
                  state       <= ST_WAIT_SCL;
                  stretch_cnt <= '0;
                end
              end
              2'd1: begin
                phase <= 2'd2;
                if (op_q == IIC_OP_START) scl_oe <= 1'b1;
                else                      sda_oe <= (op_q == IIC_OP_RESTART);
              end
              2'd2: begin
                if (op_q == IIC_OP_START) begin
                  state     <= ST_FINISH;
                  cmd_ready <= 1'b1;
                  done      <= 1'b1;
                  bus_busy  <= 1'b1;
                end else begin
                  phase <= 2'd3;
                  if (op_q == IIC_OP_RESTART) scl_oe <= 1'b1;
                end
              end
              default: begin
                state     <= ST_FINISH;
                cmd_ready <= 1'b1;
                if (op_q == IIC_OP_STOP) begin
                  bus_busy <= 1'b0;
                  scl_oe   <= 1'b0;
                  sda_oe   <= 1'b0;
                  if (sda_s) done     <= 1'b1;
                  else       arb_lost <= 1'b1;
                end else begin
                  done <= 1'b1;
                end
              end
            endcase
          end
        end

        ST_WAIT_SCL: begin
          if (scl_s) begin
            state <= ST_PHASE;
          end else if (STRETCH_MAX > 0 && stretch_cnt == STRETCH_LAST) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            err       <= 1'b1;
            bus_busy  <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
          end else if (stretch_cnt != '1) begin
            stretch_cnt <= stretch_cnt + SW'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cond_gen.sv
// tb/tb_iic_cond_gen.sv - scoreboard bench for iic_cond_gen (CLK_DIV=4, loopback open-drain pads)
module tb_iic_cond_gen;
  import iic_pkg::*;

  typedef struct {
    logic [2:0] code;
    int         cycle;
  } ev_t;

  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_ERR  = 3'b010;
  localparam logic [2:0] EV_ARB  = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic scl_force_a = 1'b0, sda_force_a = 1'b0, scl_force_b = 1'b0;

  logic cmd_ready_a, done_a, err_a, arb_lost_a, bus_busy_a, scl_oe_a, sda_oe_a, scl_in_a, sda_in_a;
  logic cmd_ready_b, done_b, err_b, arb_lost_b, bus_busy_b, scl_oe_b, sda_oe_b, scl_in_b, sda_in_b;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  ev_t exp_q[$];

  assign scl_in_a = ~scl_oe_a & ~scl_force_a;
  assign sda_in_a = ~sda_oe_a & ~sda_force_a;
  assign scl_in_b = ~scl_oe_b & ~scl_force_b;
  assign sda_in_b = ~sda_oe_b;

  iic_cond_gen #(.CLK_DIV(4), .STRETCH_MAX(100)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready_a), .done(done_a), .err(err_a), .arb_lost(arb_lost_a),
    .bus_busy(bus_busy_a), .scl_in(scl_in_a), .sda_in(sda_in_a),
    .scl_oe(scl_oe_a), .sda_oe(sda_oe_a)
  );

  iic_cond_gen #(.CLK_DIV(4), .STRETCH_MAX(20)) dut_to (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready_b), .done(done_b), .err(err_b), .arb_lost(arb_lost_b),
    .bus_busy(bus_busy_b), .scl_in(scl_in_b), .sda_in(sda_in_b),
    .scl_oe(scl_oe_b), .sda_oe(sda_oe_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done/err/arb_lost pulse on dut must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (done_a || err_a || arb_lost_a)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got code %b at cycle %0d, none expected", {arb_lost_a, err_a, done_a}, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        n_total++;
        if ({arb_lost_a, err_a, done_a} !== e.code)
          $display("FAIL event_kind: got %b expected %b", {arb_lost_a, err_a, done_a}, e.code);
        else n_pass++;
        n_total++;
        if (cyc !== e.cycle)
          $display("FAIL event_cycle: got %0d expected %0d", cyc, e.cycle);
        else n_pass++;
      end
    end
  end

  task automatic issue(input logic [1:0] op, output int t);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({scl_oe_a, sda_oe_a, cmd_ready_a, done_a, err_a, arb_lost_a, bus_busy_a} !== 7'b0010000)
      $display("FAIL reset_a: got %b expected 0010000", {scl_oe_a, sda_oe_a, cmd_ready_a, done_a, err_a, arb_lost_a, bus_busy_a});
    else n_pass++;
    n_total++;
    if ({scl_oe_b, sda_oe_b, cmd_ready_b, done_b, err_b, arb_lost_b, bus_busy_b} !== 7'b0010000)
      $display("FAIL reset_b: got %b expected 0010000", {scl_oe_b, sda_oe_b, cmd_ready_b, done_b, err_b, arb_lost_b, bus_busy_b});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    int t, sda_r, scl_r;
    logic ps, pc;
    issue(IIC_OP_START, t);
    exp_q.push_back('{EV_DONE, t + 13});
    sda_r = -1; scl_r = -1; ps = sda_oe_a; pc = scl_oe_a;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if (cmd_ready_a !== 1'b0) $display("FAIL start_ready_drop: got %b expected 0", cmd_ready_a);
        else n_pass++;
      end
      if (sda_oe_a && !ps && sda_r < 0) sda_r = cyc;
      if (scl_oe_a && !pc && scl_r < 0) scl_r = cyc;
      ps = sda_oe_a; pc = scl_oe_a;
    end
    n_total++;
    if (sda_r !== t + 5) $display("FAIL start_sda_rise: got %0d expected %0d", sda_r, t + 5);
    else n_pass++;
    n_total++;
    if (scl_r !== t + 9) $display("FAIL start_scl_rise: got %0d expected %0d", scl_r, t + 9);
    else n_pass++;
    n_total++;
    if (bus_busy_a !== 1'b1) $display("FAIL start_busy: got %b expected 1", bus_busy_a);
    else n_pass++;
  endtask

  task automatic test_stop();
    int t, scl_f, sda_f;
    logic pc, ps;
    issue(IIC_OP_STOP, t);
    exp_q.push_back('{EV_DONE, t + 19});
    scl_f = -1; sda_f = -1; pc = scl_oe_a; ps = sda_oe_a;
    n_total++;
    if (sda_oe_a !== 1'b1) $display("FAIL stop_sda_low: got %b expected 1", sda_oe_a);
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!scl_oe_a && pc && scl_f < 0) scl_f = cyc;
      if (!sda_oe_a && ps && sda_f < 0) sda_f = cyc;
      pc = scl_oe_a; ps = sda_oe_a;
    end
    n_total++;
    if (scl_f !== t + 5) $display("FAIL stop_scl_release: got %0d expected %0d", scl_f, t + 5);
    else n_pass++;
    n_total++;
    if (sda_f !== t + 11) $display("FAIL stop_sda_release: got %0d expected %0d", sda_f, t + 11);
    else n_pass++;
    n_total++;
    if (bus_busy_a !== 1'b0) $display("FAIL stop_busy: got %b expected 0", bus_busy_a);
    else n_pass++;
  endtask

  task automatic test_restart_stretch();
    int t, sda_r, scl_r;
    logic ps, pc;
    issue(IIC_OP_START, t);
    exp_q.push_back('{EV_DONE, t + 13});
    repeat (14) @(negedge clk);
    issue(IIC_OP_RESTART, t);
    scl_force_a = 1'b1;
    exp_q.push_back('{EV_DONE, t + 69});
    n_total++;
    if ({scl_oe_a, sda_oe_a} !== 2'b10) $display("FAIL restart_p0_lines: got %b expected 10", {scl_oe_a, sda_oe_a});
    else n_pass++;
    sda_r = -1; scl_r = -1; ps = sda_oe_a; pc = scl_oe_a;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (sda_oe_a && !ps && sda_r < 0) sda_r = cyc;
      if (scl_oe_a && !pc && scl_r < 0) scl_r = cyc;
      ps = sda_oe_a; pc = scl_oe_a;
      if (k == 54) begin
        @(posedge clk); #1;
        scl_force_a = 1'b0;
      end
    end
    n_total++;
    if (sda_r !== t + 61) $display("FAIL restart_sda_rise: got %0d expected %0d", sda_r, t + 61);
    else n_pass++;
    n_total++;
    if (scl_r !== t + 65) $display("FAIL restart_scl_rise: got %0d expected %0d", scl_r, t + 65);
    else n_pass++;
    n_total++;
    if (bus_busy_a !== 1'b1) $display("FAIL restart_busy: got %b expected 1", bus_busy_a);
    else n_pass++;
  endtask

  task automatic test_arb();
    int t;
    issue(IIC_OP_STOP, t);
    exp_q.push_back('{EV_ARB, t + 19});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 14) sda_force_a = 1'b1;
    end
    sda_force_a = 1'b0;
    n_total++;
    if ({scl_oe_a, sda_oe_a, bus_busy_a} !== 3'b000)
      $display("FAIL arb_release: got %b expected 000", {scl_oe_a, sda_oe_a, bus_busy_a});
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [1:0] ops[2];
    int t;
    ops[0] = IIC_OP_STOP;
    ops[1] = IIC_OP_RSVD;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], t);
      exp_q.push_back('{EV_ERR, t + 1});
      @(negedge clk);
      n_total++;
      if ({cmd_ready_a, scl_oe_a, sda_oe_a} !== 3'b000)
        $display("FAIL illegal_t1 op%0d: got %b expected 000", i, {cmd_ready_a, scl_oe_a, sda_oe_a});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({cmd_ready_a, scl_oe_a, sda_oe_a, bus_busy_a} !== 4'b1000)
        $display("FAIL illegal_t2 op%0d: got %b expected 1000", i, {cmd_ready_a, scl_oe_a, sda_oe_a, bus_busy_a});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    issue(IIC_OP_START, t);
    exp_q.push_back('{EV_DONE, t + 13});
    repeat (14) @(negedge clk);
    issue(IIC_OP_RESTART, t);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({scl_oe_a, sda_oe_a, cmd_ready_a, done_a, err_a, arb_lost_a, bus_busy_a} !== 7'b0010000)
      $display("FAIL reset_mid: got %b expected 0010000", {scl_oe_a, sda_oe_a, cmd_ready_a, done_a, err_a, arb_lost_a, bus_busy_a});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int t, err_c;
    issue(IIC_OP_START, t);
    exp_q.push_back('{EV_DONE, t + 13});
    repeat (14) @(negedge clk);
    issue(IIC_OP_STOP, t);
    scl_force_b = 1'b1;
    exp_q.push_back('{EV_DONE, t + 19});
    err_c = -1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (err_b && err_c < 0) err_c = cyc;
      if (k == 25) begin
        n_total++;
        if ({scl_oe_b, sda_oe_b, bus_busy_b} !== 3'b000)
          $display("FAIL timeout_lines: got %b expected 000", {scl_oe_b, sda_oe_b, bus_busy_b});
        else n_pass++;
      end
    end
    scl_force_b = 1'b0;
    n_total++;
    if (err_c !== t + 25) $display("FAIL timeout_err_cycle: got %0d expected %0d", err_c, t + 25);
    else n_pass++;
    n_total++;
    if (cmd_ready_b !== 1'b1) $display("FAIL timeout_ready: got %b expected 1", cmd_ready_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_restart_stretch();
    test_arb();
    test_illegal();
    test_reset_mid();
    test_timeout();
    repeat (5) @(negedge clk);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL pending_events: got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
